gpio_input_bank: RTL and testbench

Parametrised bank of NB_CH sky130 GPIOv2 input pads, each followed by a clock-domain synchroniser, a programmable debounce filter, and edge detection with sticky interrupt flags. Successor to the single-channel wrapped input pad. It sits between the chip pad ring and core logic, and delivers clean, synchronous, glitch-filtered levels plus an aggregated interrupt request.

---
 rtl/gpio_input_bank.sv | 123 ++++++++++++
 tb/tb_gpio_input_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_bank.sv
// Purpose : bank of NB_CH input-only pads, each with a synchroniser, a debounce
//           filter, edge detection and sticky edge flags feeding one interrupt.
// Latency : pad->o_raw SYNC_STAGES cycles; o_raw->o_todesign/o_edge i_deb_len+1
//           cycles; o_flag/o_irq in the same cycle as o_edge.
// Backpressure: none; free-running sampled inputs, every output is a flop.
//
// Ports:
//   i_clk, i_rst_n           core clock, synchronous active-low reset
//   i_io_pad[NB_CH]          pad nets, one input-only pad slice per bit
//   i_deb_len[DEB_WIDTH]     shared debounce threshold (0 = minimum filtering)
//   i_rise_en/i_fall_en      per-channel edge enables for flag setting
//   i_flag_clr               per-channel level-sensitive flag clear
//   o_raw                    synchronised, unfiltered level
//   o_todesign               debounced level
//   o_edge                   one-cycle pulse on any o_todesign change
//   o_flag                   sticky edge flags
//   o_irq                    OR of the flags

// Input-only pad slice: output driver disabled (OE_N high, OUT low), analog
// mux off, CMOS trip point, slow slew. Only the IN path is of interest to the
// core, so the slice reduces to the pad level appearing on IN.
module gpio_input_bank_pad (
  input  logic i_pad,
  output logic o_in
);
  assign o_in = i_pad;
endmodule

module gpio_input_bank #(
  parameter int   NB_CH       = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEB_WIDTH   = 8,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NB_CH-1:0]     i_io_pad,
  input  logic [DEB_WIDTH-1:0] i_deb_len,
  input  logic [NB_CH-1:0]     i_rise_en,
  input  logic [NB_CH-1:0]     i_fall_en,
  input  logic [NB_CH-1:0]     i_flag_clr,
  output logic [NB_CH-1:0]     o_raw,
  output logic [NB_CH-1:0]     o_todesign,
  output logic [NB_CH-1:0]     o_edge,
  output logic [NB_CH-1:0]     o_flag,
  output logic                 o_irq
);

  logic [NB_CH-1:0] pad_in;

  for (genvar g = 0; g < NB_CH; g++) begin : g_pad
    gpio_input_bank_pad u_pad (
      .i_pad (i_io_pad[g]),
      .o_in  (pad_in[g])
    );
  end

  // Stage 0 captures the pad; stage SYNC_STAGES-1 is the usable level.
  logic [SYNC_STAGES-1:0][NB_CH-1:0] sync_q, sync_d;
  logic [NB_CH-1:0]                  level_q, level_d;
  logic [NB_CH-1:0][DEB_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NB_CH-1:0]                  edge_q, edge_d;
  logic [NB_CH-1:0]                  flag_q, flag_d;
  logic                              irq_q, irq_d;
  logic [NB_CH-1:0]                  raw;
  logic [NB_CH-1:0]                  rise, fall;

  assign raw = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pad_in};
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NB_CH; i++) begin
      if (raw[i] == level_q[i]) begin
        // Any agreeing cycle restarts the count.
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= i_deb_len) begin
        // >= rather than == so a threshold lowered mid-count takes effect at
        // once; it also keeps the counter from ever wrapping.
        level_d[i] = raw[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DEB_WIDTH'(1);
      end
    end

    // Edge is registered alongside the level, so it pulses in the very cycle
    // the new level first appears on o_todesign.
    edge_d = level_d ^ level_q;
    rise   = edge_d & level_d;
    fall   = edge_d & ~level_d;

    // Set has priority over clear.
    flag_d = (rise & i_rise_en) | (fall & i_fall_en) | (flag_q & ~i_flag_clr);
    irq_d  = |flag_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q  <= {(SYNC_STAGES*NB_CH){INIT_LEVEL}};
      level_q <= {NB_CH{INIT_LEVEL}};
      cnt_q   <= '0;
      edge_q  <= '0;
      flag_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      flag_q  <= flag_d;
      irq_q   <= irq_d;
    end
  end

  assign o_raw      = raw;
  assign o_todesign = level_q;
  assign o_edge     = edge_q;
  assign o_flag     = flag_q;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_gpio_input_bank.sv
module tb_gpio_input_bank;

  localparam int   NB_CH = 4;
  localparam int   SYNC  = 2;
  localparam int   DEB_W = 8;
  localparam logic INIT  = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NB_CH-1:0] pad;
  logic [DEB_W-1:0] deb_len;
  logic [NB_CH-1:0] rise_en, fall_en, flag_clr;
  logic [NB_CH-1:0] o_raw, o_todesign, o_edge, o_flag;
  logic             o_irq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpio_input_bank #(
    .NB_CH(NB_CH), .SYNC_STAGES(SYNC), .DEB_WIDTH(DEB_W), .INIT_LEVEL(INIT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_io_pad   (pad),
    .i_deb_len  (deb_len),
    .i_rise_en  (rise_en),
    .i_fall_en  (fall_en),
    .i_flag_clr (flag_clr),
    .o_raw      (o_raw),
    .o_todesign (o_todesign),
    .o_edge     (o_edge),
    .o_flag     (o_flag),
    .o_irq      (o_irq)
  );

  // Reference model: pad history as a delay queue, filtered level plus the
  // length of the current run of cycles in which the input disagrees with it.
  logic [NB_CH-1:0] m_pipe[$];
  logic [NB_CH-1:0] m_level, m_edge, m_flag;
  logic             m_irq;
  int               m_run[NB_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe.delete();
    for (int k = 0; k < SYNC; k++) m_pipe.push_back({NB_CH{INIT}});
    m_level = {NB_CH{INIT}};
    m_edge  = '0;
    m_flag  = '0;
    m_irq   = 1'b0;
    for (int c = 0; c < NB_CH; c++) m_run[c] = 0;
  endtask

  // Advance the model using the inputs present at the edge, clock the DUT,
  // then compare every output just after the edge.
  task automatic tick();
    logic [NB_CH-1:0] raw_old;
    raw_old = m_pipe[0];
    if (!rst_n) begin
      model_reset();
    end else begin
      m_edge = '0;
      for (int c = 0; c < NB_CH; c++) begin
        if (raw_old[c] != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] > int'(deb_len)) begin
            m_level[c] = raw_old[c];
            m_run[c]   = 0;
            m_edge[c]  = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_edge[c] && (m_level[c] ? rise_en[c] : fall_en[c])) m_flag[c] = 1'b1;
        else if (flag_clr[c]) m_flag[c] = 1'b0;
      end
      m_irq = |m_flag;
      m_pipe.push_back(pad);
      void'(m_pipe.pop_front());
    end
    @(posedge clk);
    #1;
    chk("raw",      32'(o_raw),      32'(m_pipe[0]));
    chk("todesign", 32'(o_todesign), 32'(m_level));
    chk("edge",     32'(o_edge),     32'(m_edge));
    chk("flag",     32'(o_flag),     32'(m_flag));
    chk("irq",      32'(o_irq),      32'(m_irq));
  endtask

  initial begin
    int               n;
    logic             seen, f1, found;
    logic [NB_CH-1:0] prev_raw;

    model_reset();
    rst_n    = 1'b0;
    pad      = '0;
    deb_len  = DEB_W'(3);
    rise_en  = 4'b0111;
    fall_en  = 4'b1000;
    flag_clr = '0;

    // Reset with pads toggling: everything held at its reset value.
    for (int k = 0; k < 3; k++) begin
      pad = NB_CH'($urandom);
      tick();
      chk("rst_raw",      32'(o_raw),      32'({NB_CH{INIT}}));
      chk("rst_todesign", 32'(o_todesign), 32'({NB_CH{INIT}}));
      chk("rst_outs",     32'({o_edge, o_flag, o_irq}), 32'(0));
    end
    pad   = '0;
    rst_n = 1'b1;
    tick(); tick();

    // Debounce latency on ch0 with threshold 3.
    pad[0] = 1'b1;
    for (int k = 0; k < 10 && !o_raw[0]; k++) tick();
    n = 0;
    for (int k = 0; k < 20 && !o_todesign[0]; k++) begin
      tick();
      n++;
    end
    chk("deb_latency", 32'(n), 32'(4));
    chk("deb_edge", 32'(o_edge[0]), 32'(1));
    chk("deb_flag", 32'(o_flag[0]), 32'(1));
    chk("deb_irq",  32'(o_irq), 32'(1));
    tick();
    chk("deb_edge_1cyc", 32'(o_edge[0]), 32'(0));

    // Glitch of 3 synchronised cycles is rejected; a 4-cycle pulse passes.
    pad[1] = 1'b1;
    tick(); tick(); tick();
    pad[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_edge[1] || o_todesign[1]) seen = 1'b1;
    end
    chk("glitch_reject", 32'(seen), 32'(0));
    pad[1] = 1'b1;
    tick(); tick(); tick(); tick();
    pad[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (o_edge[1] && o_todesign[1]) seen = 1'b1;
    end
    chk("glitch_restart", 32'(seen), 32'(1));

    // Enable masking on ch3: rise disabled, fall enabled.
    pad[3] = 1'b1;
    n  = 0;
    f1 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 8) pad[3] = 1'b0;
      tick();
      if (o_edge[3]) begin
        n++;
        if (n == 1) f1 = o_flag[3];
      end
    end
    chk("mask_edges",       32'(n),         32'(2));
    chk("mask_rise_noflag", 32'(f1),        32'(0));
    chk("mask_fall_flag",   32'(o_flag[3]), 32'(1));

    // Set/clear collision on ch2: set wins, clear takes the next cycle.
    flag_clr[2] = 1'b1;
    pad[2]      = 1'b1;
    found       = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (o_edge[2]) begin
        found = 1'b1;
        chk("coll_set", 32'(o_flag[2]), 32'(1));
      end
    end
    chk("coll_found", 32'(found), 32'(1));
    tick();
    chk("coll_clear", 32'(o_flag[2]), 32'(0));
    flag_clr = '0;

    // Minimum filtering: every channel follows its raw level one cycle later.
    deb_len  = '0;
    rise_en  = 4'b1111;
    fall_en  = 4'b0101;
    flag_clr = '1;
    tick();
    flag_clr = '0;
    prev_raw = o_raw;
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) pad = pad ^ (NB_CH'(1) << (k / 2 % NB_CH));
      tick();
      chk("deb0_follow", 32'(o_todesign), 32'(prev_raw));
      chk("deb0_irq_or", 32'(o_irq), 32'(|o_flag));
      prev_raw = o_raw;
    end

    // Randomised run against the model, including mid-count threshold
    // changes, flag clears and occasional resets.
    for (int k = 0; k < 2000; k++) begin
      pad = pad ^ NB_CH'($urandom & $urandom);
      if ($urandom_range(0, 29) == 0) deb_len = DEB_W'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) begin
        rise_en = NB_CH'($urandom);
        fall_en = NB_CH'($urandom);
      end
      flag_clr = NB_CH'($urandom & $urandom & $urandom);
      rst_n    = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
